// File: rtl/sap_control_unit.sv
// rtl/sap_control_unit.sv - T-state sequencer and control-strobe decoder for the SAP CPU
//
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   prog          : programming-mode hold (forces step to T0, strobes inactive)
//   instr [N-1:0] : IR contents, opcode = instr[N-1:N-4]
//   cf, zf        : latched carry / zero flags for JC / JZ
//   hlt..fi       : bus control strobes (ro_ is active-low)
//   step [2:0]    : current T-state 0..4
module sap_control_unit #(
    parameter int N         = 8,
    parameter bit EARLY_END = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         prog,
    input  logic [N-1:0] instr,
    input  logic         cf,
    input  logic         zf,
    output logic         hlt,
    output logic         mi,
    output logic         ri,
    output logic         ro_,
    output logic         ii,
    output logic         io,
    output logic         ai,
    output logic         ao,
    output logic         eo,
    output logic         su,
    output logic         bi,
    output logic         oi,
    output logic         ce,
    output logic         co,
    output logic         j,
    output logic         fi,
    output logic [2:0]   step
);

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;
    logic [3:0] opcode;
    logic [2:0] last_step;
    logic       unused_operand;

    assign opcode         = instr[N-1:N-4];
    assign unused_operand = ^instr[N-5:0];
    assign step           = step_q;

    // Final microstep of the current opcode; with EARLY_END=0 every
    // instruction occupies the full T0..T4 frame.
    always_comb begin
        last_step = 3'd1;
        if (!EARLY_END) begin
            last_step = 3'd4;
        end else begin
            unique case (opcode)
                OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = 3'd2;
                OP_LDA, OP_STA:                               last_step = 3'd3;
                OP_ADD, OP_SUB:                               last_step = 3'd4;
                default:                                      last_step = 3'd1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Once halted the sequencer ignores prog and freezes; only rst escapes.
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (prog) begin
                step_d = 3'd0;
            end else if (step_q == 3'd2 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else if (step_q >= last_step) begin
                step_d = 3'd0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_comb begin
        hlt = 1'b0; mi = 1'b0; ri = 1'b0; ro_ = 1'b1;
        ii  = 1'b0; io = 1'b0; ai = 1'b0; ao  = 1'b0;
        eo  = 1'b0; su = 1'b0; bi = 1'b0; oi  = 1'b0;
        ce  = 1'b0; co = 1'b0; j  = 1'b0; fi  = 1'b0;
        if (rst) begin
            // all inactive
        end else if (halted_q) begin
            hlt = 1'b1;
        end else if (!prog) begin
            unique case (step_q)
                3'd0: begin co = 1'b1; mi = 1'b1; end
                3'd1: begin ro_ = 1'b0; ii = 1'b1; ce = 1'b1; end
                3'd2: begin
                    unique case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io = 1'b1; mi = 1'b1; end
                        OP_LDI: begin io = 1'b1; ai = 1'b1; end
                        OP_JMP: begin io = 1'b1; j = 1'b1; end
                        OP_JC:  begin io = 1'b1; j = cf; end
                        OP_JZ:  begin io = 1'b1; j = zf; end
                        OP_OUT: begin ao = 1'b1; oi = 1'b1; end
                        OP_HLT: hlt = 1'b1;
                        default: ;
                    endcase
                end
                3'd3: begin
                    unique case (opcode)
                        OP_LDA:         begin ro_ = 1'b0; ai = 1'b1; end
                        OP_ADD, OP_SUB: begin ro_ = 1'b0; bi = 1'b1; end
                        OP_STA:         begin ao = 1'b1; ri = 1'b1; end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        eo = 1'b1; ai = 1'b1; fi = 1'b1;
                        su = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_unit.sv
// tb/tb_sap_control_unit.sv - randomized model-checked bench for sap_control_unit
module tb_sap_control_unit;

    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] II  = 16'h0800, IO = 16'h0400, AI = 16'h0200, AO = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

    logic       clk = 1'b0;
    logic       rst, prog;
    logic [7:0] instr1, instr0;
    logic       cf1, zf1, cf0, zf0;
    wire [15:0] raw1, raw0;
    wire [2:0]  s1, s0;
    logic [15:0] act1, act0;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] rom [16][5];
    int          len [16];
    int          ms [2];
    bit          mh [2];

    always #5 clk = ~clk;

    sap_control_unit #(.N(8), .EARLY_END(1'b1)) dut1 (
        .clk(clk), .rst(rst), .prog(prog), .instr(instr1), .cf(cf1), .zf(zf1),
        .hlt(raw1[15]), .mi(raw1[14]), .ri(raw1[13]), .ro_(raw1[12]), .ii(raw1[11]),
        .io(raw1[10]), .ai(raw1[9]), .ao(raw1[8]), .eo(raw1[7]), .su(raw1[6]),
        .bi(raw1[5]), .oi(raw1[4]), .ce(raw1[3]), .co(raw1[2]), .j(raw1[1]),
        .fi(raw1[0]), .step(s1));

    sap_control_unit #(.N(8), .EARLY_END(1'b0)) dut0 (
        .clk(clk), .rst(rst), .prog(prog), .instr(instr0), .cf(cf0), .zf(zf0),
        .hlt(raw0[15]), .mi(raw0[14]), .ri(raw0[13]), .ro_(raw0[12]), .ii(raw0[11]),
        .io(raw0[10]), .ai(raw0[9]), .ao(raw0[8]), .eo(raw0[7]), .su(raw0[6]),
        .bi(raw0[5]), .oi(raw0[4]), .ce(raw0[3]), .co(raw0[2]), .j(raw0[1]),
        .fi(raw0[0]), .step(s0));

    // ro_ is active-low; flip it so every bit of the vector means "asserted".
    assign act1 = raw1 ^ RO;
    assign act0 = raw0 ^ RO;

    function automatic logic [3:0] op_of(int k);
        return (k == 1) ? instr1[7:4] : instr0[7:4];
    endfunction

    function automatic logic [15:0] model_vec(int k);
        logic [3:0]  op;
        logic [15:0] w;
        op = op_of(k);
        if (rst)   return 16'h0;
        if (mh[k]) return HLT;
        if (prog)  return 16'h0;
        w = rom[op][ms[k]];
        if (op == 4'h7 && !((k == 1) ? cf1 : cf0)) w = w & ~J;
        if (op == 4'h8 && !((k == 1) ? zf1 : zf0)) w = w & ~J;
        return w;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ms[k] = 0; mh[k] = 1'b0;
            end else if (!mh[k]) begin
                if (prog) ms[k] = 0;
                else if (op_of(k) == 4'hF && ms[k] == 2) mh[k] = 1'b1;
                else ms[k] = (ms[k] + 1 == ((k == 1) ? len[op_of(k)] : 5)) ? 0 : ms[k] + 1;
            end
        end
    end

    // Compare process: every negedge both instances are checked against the model.
    always @(negedge clk) begin
        if (rst) begin
            ms[0] = 0; ms[1] = 0; mh[0] = 1'b0; mh[1] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            logic [15:0] got;
            logic [2:0]  gs;
            got = (k == 1) ? act1 : act0;
            gs  = (k == 1) ? s1 : s0;
            n_vec++;
            if (got !== model_vec(k) || gs !== 3'(ms[k])) begin
                n_bad++;
                $display("FAIL model ee%0d t=%0t: strobes %h step %0d, required strobes %h step %0d",
                         k, $time, got, gs, model_vec(k), ms[k]);
            end
        end
    end

    task automatic lit(string name, logic [15:0] got, logic [15:0] exp, logic [2:0] gs, logic [2:0] es);
        n_vec++;
        if (got !== exp || gs !== es) begin
            n_bad++;
            $display("FAIL %s: strobes %h step %0d, required strobes %h step %0d", name, got, gs, exp, es);
        end
    endtask

    task automatic edge_set();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int o = 0; o < 16; o++) begin
            for (int s = 0; s < 5; s++) rom[o][s] = 16'h0;
            rom[o][0] = CO | MI;
            rom[o][1] = RO | II | CE;
            len[o] = 2;
        end
        rom[1][2] = IO | MI; rom[1][3] = RO | AI;            len[1] = 4;
        rom[2][2] = IO | MI; rom[2][3] = RO | BI; rom[2][4] = EO | AI | FI;      len[2] = 5;
        rom[3][2] = IO | MI; rom[3][3] = RO | BI; rom[3][4] = EO | AI | FI | SU; len[3] = 5;
        rom[4][2] = IO | MI; rom[4][3] = AO | RI;            len[4] = 4;
        rom[5][2] = IO | AI;  len[5] = 3;
        rom[6][2] = IO | J;   len[6] = 3;
        rom[7][2] = IO | J;   len[7] = 3;
        rom[8][2] = IO | J;   len[8] = 3;
        rom[14][2] = AO | OI; len[14] = 3;
        rom[15][2] = HLT;     len[15] = 3;
        ms[0] = 0; ms[1] = 0; mh[0] = 1'b0; mh[1] = 1'b0;

        rst = 1'b1; prog = 1'b0;
        instr1 = 8'h1E; cf1 = 1'b0; zf1 = 1'b0;
        instr0 = 8'h00; cf0 = 1'b0; zf0 = 1'b0;

        repeat (3) begin @(negedge clk); lit("reset", act1, 16'h0, s1, 3'd0); end
        edge_set(); rst = 1'b0;
        @(negedge clk); lit("fetch_t0", act1, CO | MI, s1, 3'd0);
        @(negedge clk); lit("fetch_t1", act1, RO | II | CE, s1, 3'd1);
        @(negedge clk); lit("lda_t2", act1, IO | MI, s1, 3'd2);
        @(negedge clk); lit("lda_t3", act1, RO | AI, s1, 3'd3);
        edge_set(); instr1 = 8'h3F;
        @(negedge clk); lit("lda_end", act1, CO | MI, s1, 3'd0);
        @(negedge clk);
        @(negedge clk); lit("sub_t2", act1, IO | MI, s1, 3'd2);
        @(negedge clk); lit("sub_t3", act1, RO | BI, s1, 3'd3);
        @(negedge clk); lit("sub_t4", act1, EO | AI | SU | FI, s1, 3'd4);
        edge_set(); instr1 = 8'h7A; cf1 = 1'b0;
        @(negedge clk); lit("sub_end", act1, CO | MI, s1, 3'd0);
        @(negedge clk);
        @(negedge clk); lit("jc_not", act1, IO, s1, 3'd2);
        edge_set(); cf1 = 1'b1;
        @(negedge clk); lit("jc_not_end", act1, CO | MI, s1, 3'd0);
        @(negedge clk);
        @(negedge clk); lit("jc_taken", act1, IO | J, s1, 3'd2);
        edge_set(); instr1 = 8'h8A; zf1 = 1'b0;
        @(negedge clk); @(negedge clk);
        @(negedge clk); lit("jz_not", act1, IO, s1, 3'd2);
        edge_set(); zf1 = 1'b1;
        @(negedge clk); @(negedge clk);
        @(negedge clk); lit("jz_taken", act1, IO | J, s1, 3'd2);
        edge_set(); instr1 = 8'hF0;
        @(negedge clk); @(negedge clk);
        @(negedge clk); lit("hlt_t2", act1, HLT, s1, 3'd2);
        for (int i = 0; i < 10; i++) begin
            edge_set(); prog = i[0];
            @(negedge clk); lit("halted", act1, HLT, s1, 3'd2);
        end
        edge_set(); prog = 1'b0; rst = 1'b1;
        @(negedge clk); lit("halt_rst", act1, 16'h0, s1, 3'd0);
        edge_set(); rst = 1'b0; instr1 = 8'h2C; instr0 = 8'h00;
        @(negedge clk); lit("restart_t0", act1, CO | MI, s1, 3'd0);
        @(negedge clk); @(negedge clk);
        edge_set(); prog = 1'b1;
        @(negedge clk); lit("prog_t3", act1, 16'h0, s1, 3'd3);
        @(negedge clk); lit("prog_hold", act1, 16'h0, s1, 3'd0);
        edge_set(); prog = 1'b0;
        @(negedge clk); lit("prog_drop", act1, CO | MI, s1, 3'd0);
        lit("nop5_0", act0, CO | MI, s0, 3'd0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk); lit("nop5_step", act0, (i == 1) ? (RO | II | CE) : 16'h0, s0, 3'(i));
        end
        @(negedge clk); lit("nop5_wrap", act0, CO | MI, s0, 3'd0);

        for (int c = 0; c < 4000; c++) begin
            edge_set();
            rst  = ($urandom_range(99) < 2) || ((mh[0] || mh[1]) && $urandom_range(99) < 8);
            prog = ($urandom_range(99) < 4);
            for (int k = 0; k < 2; k++) begin
                if (ms[k] == 0 && !mh[k]) begin
                    logic [7:0] v;
                    v = 8'($urandom);
                    if (v[7:4] == 4'hF && $urandom_range(3) != 0) v[7:4] = 4'h2;
                    if (k == 1) begin instr1 = v; cf1 = 1'($urandom); zf1 = 1'($urandom); end
                    else        begin instr0 = v; cf0 = 1'($urandom); zf0 = 1'($urandom); end
                end
            end
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
